// File: rtl/pll_sup_pkg.sv
// Shared state encoding and period grading for the PLL core supervisor.
package pll_sup_pkg;

   localparam logic [1:0] ST_IDLE_C    = 2'd0;
   localparam logic [1:0] ST_MEASURE_C = 2'd1;
   localparam logic [1:0] ST_HOLD_C    = 2'd2;
   localparam logic [1:0] ST_RUN_C     = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE_C,
      MEASURE = ST_MEASURE_C,
      HOLD    = ST_HOLD_C,
      RUN     = ST_RUN_C
   } state_e;

   function automatic logic period_ok(
      input int p,
      input int mult,
      input int tol
   );
      return (p >= mult - tol) && (p <= mult + tol);
   endfunction

endpackage

// File: rtl/pll_ref_edge_det.sv
// Two-flop synchroniser for the reference clock plus rising-edge detect.
module pll_ref_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic ref_in,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = ref_in;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/pll_core_supervisor.sv
// Lock supervisor: grades ref periods in clk cycles, sequences core reset.
// Optional PLL_LOSS_RECOVERY_EN: drop back to MEASURE on a bad period in RUN.
module pll_core_supervisor
   import pll_sup_pkg::*;
#(
   parameter int OUT_W    = 10,
   parameter int MULT     = 8,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int RST_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_vco,
   input  logic             ref_clk,
   input  logic [OUT_W-1:0] core_out,
   output logic             core_reset,
   output logic [OUT_W-1:0] out,
   output logic             locked
`ifdef PLL_LOSS_RECOVERY_EN
   ,
   output logic             lock_lost
`endif
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic             armed_q, armed_d;
   logic             core_reset_q, core_reset_d;
   logic             locked_q, locked_d;
   logic [OUT_W-1:0] out_q, out_d;
`ifdef PLL_LOSS_RECOVERY_EN
   logic             lost_q, lost_d;
`endif

   logic rise;
   logic sat;
   logic evt;
   logic good;

   pll_ref_edge_det u_edge (
      .clk    (clk),
      .reset  (reset),
      .ref_in (ref_clk),
      .rise   (rise)
   );

   // A saturated counter is a period event on its own (no-ref timeout)
   assign sat  = (cnt_q == CNT_MAX);
   assign evt  = rise | sat;
   assign good = ~sat & period_ok(int'(cnt_q), MULT, TOL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      hcnt_d  = hcnt_q;
      armed_d = armed_q;

      if (state_q != IDLE) begin
         cnt_d = evt ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (en_vco) state_d = MEASURE;
         end
         MEASURE: begin
            armed_d = armed_q | rise;
            if (evt && armed_q) begin
               if (!good) begin
                  gcnt_d = '0;
               end else if (gcnt_q == GW'(LOCK_CNT - 1)) begin
                  state_d = HOLD;
                  gcnt_d  = '0;
                  hcnt_d  = '0;
               end else begin
                  gcnt_d = gcnt_q + GW'(1);
               end
            end
         end
         HOLD: begin
            if (evt && !good) begin
               state_d = MEASURE;
               gcnt_d  = '0;
               hcnt_d  = '0;
            end else if (hcnt_q == HW'(RST_HOLD - 1)) begin
               state_d = RUN;
               hcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         RUN: begin
`ifdef PLL_LOSS_RECOVERY_EN
            if (evt && !good) begin
               state_d = MEASURE;
               gcnt_d  = '0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (!en_vco) begin
         state_d = IDLE;
         cnt_d   = '0;
         gcnt_d  = '0;
         hcnt_d  = '0;
         armed_d = 1'b0;
      end

      // Outputs follow the next state so they line up with state_q
      core_reset_d = (state_d != RUN);
      locked_d     = (state_d == HOLD) || (state_d == RUN);
      out_d        = (state_d == RUN) ? core_out : '0;
`ifdef PLL_LOSS_RECOVERY_EN
      lost_d = lost_q | ((state_q == RUN) && (state_d == MEASURE));
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gcnt_q       <= '0;
         hcnt_q       <= '0;
         armed_q      <= 1'b0;
         core_reset_q <= 1'b1;
         locked_q     <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gcnt_q       <= gcnt_d;
         hcnt_q       <= hcnt_d;
         armed_q      <= armed_d;
         core_reset_q <= core_reset_d;
         locked_q     <= locked_d;
         out_q        <= out_d;
      end
   end

`ifdef PLL_LOSS_RECOVERY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lost_q <= 1'b0;
      else       lost_q <= lost_d;
   end

   assign lock_lost = lost_q;
`endif

   assign core_reset = core_reset_q;
   assign locked     = locked_q;
   assign out        = out_q;

endmodule

// File: tb/tb_pll_core_supervisor.sv
// Directed bench for pll_core_supervisor: lock sequencing, grading, timeout.
module tb_pll_core_supervisor;

   localparam int OUT_W = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             en_vco;
   logic             ref_clk;
   logic [OUT_W-1:0] core_out;
   logic             core_reset;
   logic [OUT_W-1:0] out;
   logic             locked;
`ifdef PLL_LOSS_RECOVERY_EN
   logic             lock_lost;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit sched [0:511];

   always #5 clk = ~clk;

   pll_core_supervisor dut (
      .clk        (clk),
      .reset      (reset),
      .en_vco     (en_vco),
      .ref_clk    (ref_clk),
      .core_out   (core_out),
      .core_reset (core_reset),
      .out        (out),
      .locked     (locked)
`ifdef PLL_LOSS_RECOVERY_EN
      ,
      .lock_lost  (lock_lost)
`endif
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // A scheduled rise drives ref high for two clk cycles
   task automatic step();
      logic r;
      r = sched[cyc];
      if (cyc > 0) r = r | sched[cyc-1];
      ref_clk = r;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic restart();
      reset    = 1'b1;
      en_vco   = 1'b0;
      ref_clk  = 1'b0;
      core_out = 10'h155;
      foreach (sched[i]) sched[i] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic sched_steady();
      int r [9] = '{4, 12, 20, 28, 36, 44, 52, 64, 72};
      foreach (r[i]) sched[r[i]] = 1'b1;
   endtask

   initial begin
      reset    = 1'b1;
      en_vco   = 1'b0;
      ref_clk  = 1'b0;
      core_out = 10'h155;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_out", 32'(out), 0);
      chk("rst_locked", 32'(locked), 0);
`ifdef PLL_LOSS_RECOVERY_EN
      chk("rst_lock_lost", 32'(lock_lost), 0);
`endif

      // en_vco low: ref edges must never lead to lock
      restart();
      sched_steady();
      run_to(80);
      chk("idle_locked", 32'(locked), 0);
      chk("idle_core_reset", 32'(core_reset), 1);

      // Steady period 8: lock, hold, run, data path, period 12, drop
      restart();
      en_vco = 1'b1;
      sched_steady();
      run_to(38);
      chk("b_pre_lock", 32'(locked), 0);
      run_to(39);
      chk("b_lock", 32'(locked), 1);
      chk("b_hold_rst", 32'(core_reset), 1);
      run_to(54);
      chk("b_hold_end_rst", 32'(core_reset), 1);
      chk("b_hold_out", 32'(out), 0);
      run_to(55);
      chk("b_run_rst", 32'(core_reset), 0);
      chk("b_run_out0", 32'(out), 32'h155);
      run_to(60);
      core_out = 10'h2A5;
      step();
      chk("b_out_2a5", 32'(out), 32'h2A5);
      core_out = 10'h0F0;
      step();
      chk("b_out_0f0", 32'(out), 32'h0F0);
      run_to(70);
`ifdef PLL_LOSS_RECOVERY_EN
      chk("b_p12_rst", 32'(core_reset), 1);
      chk("b_p12_lost", 32'(lock_lost), 1);
      chk("b_p12_locked", 32'(locked), 0);
      chk("b_p12_out", 32'(out), 0);
`else
      chk("b_p12_rst", 32'(core_reset), 0);
      chk("b_p12_locked", 32'(locked), 1);
      chk("b_p12_out", 32'(out), 32'h0F0);
`endif
      run_to(75);
      en_vco = 1'b0;
      step();
      chk("b_drop_rst", 32'(core_reset), 1);
      chk("b_drop_out", 32'(out), 0);
      chk("b_drop_locked", 32'(locked), 0);

      // Periods 8,8,11,8,8,8,8: the 11 clears the good count
      restart();
      en_vco = 1'b1;
      begin
         int r [8] = '{4, 12, 20, 31, 39, 47, 55, 63};
         foreach (r[i]) sched[r[i]] = 1'b1;
      end
      run_to(58);
      chk("c_no_early", 32'(locked), 0);
      run_to(65);
      chk("c_pre_lock", 32'(locked), 0);
      run_to(66);
      chk("c_lock", 32'(locked), 1);

      // Tolerance edges: 9 and 7 good, 10 bad
      restart();
      en_vco = 1'b1;
      begin
         int r [8] = '{4, 13, 20, 30, 38, 46, 54, 62};
         foreach (r[i]) sched[r[i]] = 1'b1;
      end
      run_to(42);
      chk("d_p10_bad", 32'(locked), 0);
      run_to(64);
      chk("d_pre_lock", 32'(locked), 0);
      run_to(65);
      chk("d_lock", 32'(locked), 1);

      // Three good periods, then ref silent until the counter saturates
      restart();
      en_vco = 1'b1;
      begin
         int r [8] = '{4, 12, 20, 28, 291, 299, 307, 315};
         foreach (r[i]) sched[r[i]] = 1'b1;
      end
      run_to(250);
      chk("e_wait_locked", 32'(locked), 0);
      chk("e_wait_rst", 32'(core_reset), 1);
      run_to(295);
      chk("e_sat_cleared", 32'(locked), 0);
      run_to(317);
      chk("e_pre_lock", 32'(locked), 0);
      run_to(318);
      chk("e_lock", 32'(locked), 1);

      // Asynchronous reset between clk edges while in RUN
      restart();
      en_vco = 1'b1;
      core_out = 10'h2A5;
      sched_steady();
      run_to(60);
      chk("f_pre_out", 32'(out), 32'h2A5);
      chk("f_pre_rst", 32'(core_reset), 0);
      #2;
      reset = 1'b1;
      #1;
      chk("f_async_rst", 32'(core_reset), 1);
      chk("f_async_out", 32'(out), 0);
      chk("f_async_locked", 32'(locked), 0);
      #2;
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pll_core_supervisor.md
PLL_CORE_SUPERVISOR -- requirements
Module: pll_core_supervisor

Interface
REQ-001 SHALL have parameter OUT_W, default 10: width of core output bus.
REQ-002 SHALL have parameter MULT, default 8: expected clk cycles per ref period.
REQ-003 SHALL have parameter TOL, default 1: allowed deviation of a measured period from MULT, in clk cycles.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive good ref periods required to declare lock.
REQ-005 SHALL have parameter RST_HOLD, default 16: clk cycles core_reset stays high after lock.
REQ-006 SHALL have parameter CNT_W, default 8: period counter width; 2**CNT_W-1 > MULT+TOL.
REQ-007 SHALL have port clk, input, 1: PLL output clock; the only clock.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port en_vco, input, 1: VCO enable; low forces IDLE.
REQ-010 SHALL have port ref, input, 1: reference clock, asynchronous, sampled as data.
REQ-011 SHALL have port core_out, input, OUT_W: core result bus.
REQ-012 SHALL have port core_reset, output, 1: active-high reset to the core.
REQ-013 SHALL have port out, output, OUT_W: registered core result.
REQ-014 SHALL have port locked, output, 1: high in HOLD and RUN.

Function
REQ-015 ref SHALL pass a 2-flop synchroniser plus one edge flop; a rising edge is synced=1 with previous=0.
REQ-016 Period counter SHALL increment every cycle, saturate at 2**CNT_W-1, and load 1 on a rising edge.
REQ-017 On a rising edge the counter value before load SHALL be the period; good = |period-MULT| <= TOL.
REQ-018 Counter saturation SHALL count as one bad period, then the counter SHALL reload 1 (no-ref timeout).
REQ-019 FSM states SHALL be IDLE, MEASURE, HOLD, RUN.
REQ-020 IDLE -> MEASURE when en_vco=1; the first edge in MEASURE only starts measurement and is not graded.
REQ-021 MEASURE: good-count SHALL increment on a good period and clear on a bad one; -> HOLD when it reaches LOCK_CNT.
REQ-022 HOLD SHALL count RST_HOLD cycles, then -> RUN.
REQ-023 core_reset SHALL be 1 in IDLE, MEASURE and HOLD, and 0 in RUN.
REQ-024 In RUN, out SHALL register core_out every cycle (1-cycle latency); in all other states out SHALL be 0.
REQ-025 en_vco=0 in any state SHALL go to IDLE next cycle, clearing counters; core_reset=1 in that same cycle.
REQ-026 A bad period in HOLD SHALL return to MEASURE with good-count cleared.
REQ-027 A simultaneous edge and saturation SHALL be treated as one edge with the saturated period, graded bad.

Reset
REQ-028 On reset: state IDLE, all counters 0, synchroniser flops 0, core_reset=1, out=0, locked=0.
REQ-029 Reset asserted mid-RUN SHALL force core_reset=1 immediately, asynchronously.

Configuration
REQ-030 With PLL_LOSS_RECOVERY_EN defined: a bad period in RUN SHALL go to MEASURE, assert core_reset, and set sticky output lock_lost (1 bit, cleared only by reset).
REQ-031 Without PLL_LOSS_RECOVERY_EN: RUN SHALL ignore period quality, the lock_lost port SHALL be absent, and only en_vco=0 or reset leaves RUN.

Structure
REQ-032 The FSM state enum and the state encoding constants SHALL live in package pll_sup_pkg.
REQ-033 Synchroniser plus edge detect SHALL be sub-module pll_ref_edge_det.

Verification
REQ-034 Default parameters, ref period 8 clk, en_vco=1 -> locked=1 after the 5th ref edge (first edge ungraded, then 4 good periods); core_reset falls 16 cycles later.
REQ-035 Periods 8,8,11,8,8,8,8 -> good-count clears at 11; lock on the 4th good period after it.
REQ-036 In RUN, core_out=10'h2A5 -> out=10'h2A5 one cycle later; en_vco drops -> next cycle state IDLE, out=0, core_reset=1.
REQ-037 ref held low for 300 cycles in MEASURE -> saturation at 255 graded bad, no lock.
REQ-038 PLL_LOSS_RECOVERY_EN defined, period 12 in RUN -> core_reset=1, lock_lost=1, state MEASURE; without the macro, the same period leaves RUN unchanged.
REQ-039 Reset asserted mid-RUN between clk edges -> core_reset=1 and out=0 without a clk edge.
